// File: rtl/fm_radio_pkg.sv
// Shared constants and types for the FM radio audio path.
package fm_radio_pkg;

   localparam int I2S_SLOT_BITS = 32;     // BCLK cycles per I2S channel slot
   localparam int AUDIO_WIDTH   = 16;     // audio sample width, two's complement
   localparam int AUDIO_FS      = 32000;  // audio sample rate in Hz

   typedef logic signed [AUDIO_WIDTH-1:0] audio_sample_t;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S master timing: divides clk down to BCLK, counts bit positions within a
// two-slot frame, drives LRCLK and exposes the falling-edge / frame strobes
// the serializer shifts on.
module i2s_clkgen
   import fm_radio_pkg::*;
#(
   parameter int CLK_DIV   = 2,
   parameter int SLOT_BITS = I2S_SLOT_BITS,
   localparam int CNT_W    = $clog2(2 * SLOT_BITS),
   localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   output logic             bclk,
   output logic             lrclk,
   output logic             fall_strobe,   // this clk edge takes bclk 1->0
   output logic             frame_start,   // this fall wraps bit_cnt to 0
   output logic [CNT_W-1:0] bit_cnt_next   // bit position after this fall
);

   logic [DIV_W-1:0] div_cnt;
   logic [CNT_W-1:0] bit_cnt;
   logic             div_wrap;

   // Decode the edge events the serializer must act on in the same clk.
   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      div_wrap     = (div_cnt == DIV_W'(CLK_DIV - 1));
      fall_strobe  = enable & div_wrap & bclk;
      bit_cnt_next = bit_cnt + CNT_W'(1);
      if (bit_cnt == CNT_W'(2 * SLOT_BITS - 1)) begin
         bit_cnt_next = '0;
      end
      frame_start  = fall_strobe & (bit_cnt_next == '0);
   end

   // Divider, bit clock and frame position; disable parks everything at reset values.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         bclk    <= 1'b0;
         lrclk   <= 1'b0;
      end else if (!enable) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         bclk    <= 1'b0;
         lrclk   <= 1'b0;
      end else begin
         if (div_wrap) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
         if (fall_strobe) begin
            bit_cnt <= bit_cnt_next;
            lrclk   <= (bit_cnt_next >= CNT_W'(SLOT_BITS));
         end
      end
   end

endmodule

// File: rtl/i2s_audio_tx.sv
// I2S master transmitter for the mono audio path: accepts one sample per
// frame through valid/ready into a one-entry holding buffer and plays it
// MSB first on both the left and right slots.
module i2s_audio_tx
   import fm_radio_pkg::*;
#(
   parameter int width     = AUDIO_WIDTH,
   parameter int CLK_DIV   = 2,
   parameter int SLOT_BITS = I2S_SLOT_BITS
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic signed [width-1:0] in,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic                    bclk,
   output logic                    lrclk,
   output logic                    sdata,
   output logic                    underrun
);

   localparam int CNT_W = $clog2(2 * SLOT_BITS);
   localparam int IDX_W = (width > 1) ? $clog2(width) : 1;

   logic             fall_strobe;
   logic             frame_start;
   logic [CNT_W-1:0] bit_cnt_next;

   logic             holding_full;
   logic [width-1:0] holding;
   logic [width-1:0] cur;
   logic             sdata_next;
   logic [IDX_W-1:0] idx;
   int               pos;

   i2s_clkgen #(
      .CLK_DIV   (CLK_DIV),
      .SLOT_BITS (SLOT_BITS)
   ) u_clkgen (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .bclk         (bclk),
      .lrclk        (lrclk),
      .fall_strobe  (fall_strobe),
      .frame_start  (frame_start),
      .bit_cnt_next (bit_cnt_next)
   );

   assign in_ready = ~holding_full;

   // Pick the data bit for the new slot position: one-bit I2S delay, MSB first,
   // zero padding after the LSB.
   always_comb begin
      pos        = int'(bit_cnt_next) % SLOT_BITS;
      idx        = IDX_W'(width - pos);
      sdata_next = 1'b0;
      if (pos >= 1 && pos <= width) begin
         sdata_next = cur[idx];
      end
   end

   // Holding buffer, current sample, serial data and underrun flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the sample registers are reset too, so a reset drops any
         // buffered sample and the first frame after it plays silence.
         holding_full <= 1'b0;
         holding      <= '0;
         cur          <= '0;
         sdata        <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         underrun <= frame_start & ~holding_full;

         if (!enable) begin
            sdata <= 1'b0;
         end else if (fall_strobe) begin
            sdata <= sdata_next;
         end

         if (frame_start && holding_full) begin
            cur          <= holding;
            holding_full <= 1'b0;
         end else if (in_valid && !holding_full) begin
            holding      <= in;
            holding_full <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Self-checking bench for i2s_audio_tx: a time-based frame model checked every
// clk, a slot decoder that rebuilds received words, and directed scenarios.
module tb_i2s_audio_tx;
   import fm_radio_pkg::*;

   localparam int W          = 16;
   localparam int CD         = 2;
   localparam int SB         = 32;
   localparam int FRAME_BITS = 2 * SB;

   logic                clk = 1'b0;
   logic                reset_n = 1'b1;
   logic                enable = 1'b0;
   logic                in_valid = 1'b0;
   audio_sample_t       din = '0;
   logic                in_ready, bclk, lrclk, sdata, underrun;

   int vectors = 0;
   int miscompares = 0;
   bit run = 1'b0;

   always #5 clk = ~clk;

   i2s_audio_tx #(
      .width     (W),
      .CLK_DIV   (CD),
      .SLOT_BITS (SB)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .enable   (enable),
      .in       (din),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .bclk     (bclk),
      .lrclk    (lrclk),
      .sdata    (sdata),
      .underrun (underrun)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Timing follows from the clk count since (re)start; data from which sample
   // each frame was assigned at its boundary.
   int          m_t;
   bit          m_full;
   logic [15:0] m_hold, m_cur;
   bit          m_sdata, m_und;

   always @(posedge clk or negedge reset_n) begin
      bit acc;
      int n, p;
      logic [15:0] tmp;
      if (!reset_n) begin
         m_t = 0; m_full = 0; m_hold = '0; m_cur = '0; m_sdata = 0; m_und = 0;
      end else begin
         acc   = in_valid && !m_full;
         m_und = 0;
         if (!enable) begin
            m_t = 0;
            m_sdata = 0;
         end else begin
            m_t++;
            if (m_t % (2 * CD) == 0) begin
               n = (m_t / (2 * CD)) % FRAME_BITS;
               p = n % SB;
               if (p >= 1 && p <= W) begin
                  tmp = m_cur >> (W - p);
                  m_sdata = tmp[0];
               end else begin
                  m_sdata = 0;
               end
               if (n == 0) begin
                  if (m_full) begin m_cur = m_hold; m_full = 0; end
                  else m_und = 1;
               end
            end
         end
         if (acc) begin m_hold = din; m_full = 1; end
      end
   end

   // Compare every clk, away from the active edge.
   always @(negedge clk) begin
      if (run && reset_n) begin
         check("bclk",     bclk,     32'((m_t / CD) % 2));
         check("lrclk",    lrclk,    32'(((m_t / (2 * CD)) % FRAME_BITS) >= SB));
         check("sdata",    sdata,    32'(m_sdata));
         check("underrun", underrun, 32'(m_und));
         check("in_ready", in_ready, 32'(!m_full));
      end
   end

   // ---------------- slot decoder ----------------
   // Rebuilds the 16-bit word of each slot from the pins alone.
   int          pos = 99;
   logic        lr_q = 1'b0, bclk_q = 1'b0;
   logic [15:0] shreg = '0, last_left = '0, last_right = '0;
   int          right_cnt = 0, und_cnt = 0;

   always @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pos = 99; lr_q = 0; bclk_q = 0; right_cnt = 0; und_cnt = 0;
      end else begin
         if (underrun) und_cnt++;
         if (!enable) begin
            pos = 99; lr_q = 0;
         end else if (bclk_q && !bclk) begin
            if (lrclk != lr_q) pos = 0;
            else if (pos < 99) pos++;
            lr_q = lrclk;
            if (pos >= 1 && pos <= W) shreg = {shreg[14:0], sdata};
            if (pos == W) begin
               if (lrclk) begin last_right = shreg; right_cnt++; end
               else last_left = shreg;
            end
         end
         bclk_q = bclk;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      reset_n = 0; #3; reset_n = 1;
      step(1);
   endtask

   task automatic push(input logic [15:0] v);
      bit ok = 0;
      din = v; in_valid = 1;
      for (int i = 0; i < 700 && !ok; i++) begin
         ok = in_ready;
         step(1);
      end
      in_valid = 0;
      if (!ok) begin
         vectors++; miscompares++;
         $display("FAIL push_%h: got no accept, required accept within 700 clk", v);
      end
   endtask

   task automatic wait_right(input int target);
      for (int i = 0; i < 1200 && right_cnt < target; i++) step(1);
      check("right_slot_count", right_cnt, target);
   endtask

   task automatic wait_left_pos(input int target);
      for (int i = 0; i < 1200 && !(pos == target && lr_q == 0); i++) step(1);
      check("left_slot_pos", pos, target);
   endtask

   // ---------------- scenarios ----------------
   initial begin
      // 1: reset values, free-running with no input
      #2; reset_n = 0; enable = 1;
      #1;
      check("rst_bclk", bclk, 0);
      check("rst_lrclk", lrclk, 0);
      check("rst_sdata", sdata, 0);
      check("rst_underrun", underrun, 0);
      check("rst_in_ready", in_ready, 1);
      #4; reset_n = 1; run = 1;
      step(2);
      check("t1_bclk_high_after_2clk", bclk, 1);
      step(2);
      check("t1_bclk_low_after_4clk", bclk, 0);
      step(516);
      check("t1_underrun_per_frame", und_cnt, 2);
      check("t1_right_silent", last_right, 16'h0000);

      // 2: single sample before the first wrap
      do_reset();
      push(16'hA5C3);
      check("t2_in_ready_low", in_ready, 0);
      wait_right(2);
      check("t2_left", last_left, 16'hA5C3);
      check("t2_right", last_right, 16'hA5C3);
      check("t2_no_underrun", und_cnt, 0);

      // 3: back-to-back samples, second stalls until the boundary
      push(16'h8000);
      push(16'h7FFF);
      check("t3_in_ready_low", in_ready, 0);
      wait_right(3);
      check("t3_left_8000", last_left, 16'h8000);
      check("t3_right_8000", last_right, 16'h8000);
      wait_right(4);
      check("t3_left_7fff", last_left, 16'h7FFF);
      check("t3_right_7fff", last_right, 16'h7FFF);
      check("t3_no_underrun", und_cnt, 0);

      // 4: input stops, last sample repeats with underrun each frame
      push(16'h1234);
      wait_right(5);
      check("t4_left_1234", last_left, 16'h1234);
      check("t4_no_underrun_yet", und_cnt, 0);
      wait_right(7);
      check("t4_left_repeat", last_left, 16'h1234);
      check("t4_right_repeat", last_right, 16'h1234);
      check("t4_underruns", und_cnt, 2);

      // 5: disable mid right slot, push while idle, re-enable
      check("t5_lrclk_right_slot", lrclk, 1);
      enable = 0;
      step(1);
      check("t5_bclk_idle", bclk, 0);
      check("t5_lrclk_idle", lrclk, 0);
      check("t5_sdata_idle", sdata, 0);
      push(16'h5555);
      check("t5_accept_while_idle", in_ready, 0);
      step(40);
      check("t5_no_underrun_idle", und_cnt, 2);
      enable = 1;
      wait_right(9);
      check("t5_left_5555", last_left, 16'h5555);
      check("t5_right_5555", last_right, 16'h5555);
      check("t5_underruns", und_cnt, 2);

      // 6: async reset mid left slot with the holding buffer full
      wait_left_pos(2);
      push(16'hAAAA);
      check("t6_holding_full", in_ready, 0);
      wait_left_pos(20);
      reset_n = 0;
      #1;
      check("t6_rst_bclk", bclk, 0);
      check("t6_rst_lrclk", lrclk, 0);
      check("t6_rst_sdata", sdata, 0);
      check("t6_rst_underrun", underrun, 0);
      check("t6_rst_in_ready", in_ready, 1);
      #2; reset_n = 1;
      step(1);
      wait_right(1);
      check("t6_right_frame0", last_right, 16'h0000);
      wait_right(2);
      check("t6_left_frame1", last_left, 16'h0000);
      check("t6_right_frame1", last_right, 16'h0000);
      check("t6_underrun_dropped", und_cnt, 1);

      step(4);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
